// File: rtl/ceres_param.sv
// Shared constants and types for the instruction fetch front end:
// opcodes, fetch-buffer parameter limits and the aligned-instruction bundle.
package ceres_param;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam int unsigned FETCH_W_MIN = 32;
    localparam int unsigned FETCH_W_MAX = 128;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] raw;
        logic [31:0] pc;
        logic        is_compressed;
        logic        illegal;
    } aligned_instr_t;

    // FETCH_W must be a power of two in range; DEPTH a power of two holding two beats.
    function automatic bit fab_params_ok(int unsigned fetch_w, int unsigned depth);
        bit w_ok;
        bit d_ok;
        w_ok = (fetch_w >= FETCH_W_MIN) && (fetch_w <= FETCH_W_MAX) &&
               ((fetch_w & (fetch_w - 1)) == 0);
        d_ok = (depth != 0) && ((depth & (depth - 1)) == 0) && (depth >= 2 * (fetch_w / 16));
        return w_ok && d_ok;
    endfunction

endpackage

// File: rtl/compressed_decoder.sv
// Expands a 16-bit RV32C instruction into its 32-bit equivalent; 32-bit
// encodings pass through unchanged.
module compressed_decoder
    import ceres_param::*;
#(
    parameter bit C_EXT_EN = 1'b1
) (
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic        is_compressed_o,
    output logic        illegal_o
);

    logic [15:0] w_c;
    logic [4:0]  w_rdp;
    logic [4:0]  w_rs2p;
    logic [20:1] w_jimm;
    logic [12:1] w_bimm;
    logic [2:0]  w_alu_f3;

    assign w_c      = instr_i[15:0];
    assign w_rdp    = {2'b01, w_c[9:7]};
    assign w_rs2p   = {2'b01, w_c[4:2]};
    assign w_jimm   = {{9{w_c[12]}}, w_c[12], w_c[8], w_c[10:9], w_c[6], w_c[7], w_c[2], w_c[11], w_c[5:3]};
    assign w_bimm   = {{4{w_c[12]}}, w_c[12], w_c[6:5], w_c[2], w_c[11:10], w_c[4:3]};
    assign w_alu_f3 = (w_c[6:5] == 2'b00) ? 3'b000 :
                      (w_c[6:5] == 2'b01) ? 3'b100 :
                      (w_c[6:5] == 2'b10) ? 3'b110 : 3'b111;

    always_comb begin
        instr_o         = instr_i;
        is_compressed_o = 1'b0;
        illegal_o       = 1'b0;
        if (w_c[1:0] != 2'b11) begin
            if (!C_EXT_EN) begin
                illegal_o = 1'b1;
            end else begin
                is_compressed_o = 1'b1;
                instr_o         = {16'h0, w_c};
                case ({w_c[1:0], w_c[15:13]})
                    5'b00_000: begin
                        instr_o   = {2'b00, w_c[10:7], w_c[12:11], w_c[5], w_c[6], 2'b00, 5'd2, 3'b000, w_rs2p, OPC_OP_IMM};
                        illegal_o = (w_c[12:5] == 8'h00);
                    end
                    5'b00_010: instr_o = {5'b0, w_c[5], w_c[12:10], w_c[6], 2'b00, w_rdp, 3'b010, w_rs2p, OPC_LOAD};
                    5'b00_110: instr_o = {5'b0, w_c[5], w_c[12], w_rs2p, w_rdp, 3'b010, w_c[11:10], w_c[6], 2'b00, OPC_STORE};
                    5'b01_000: instr_o = {{7{w_c[12]}}, w_c[6:2], w_c[11:7], 3'b000, w_c[11:7], OPC_OP_IMM};
                    5'b01_001, 5'b01_101:
                        instr_o = {w_jimm[20], w_jimm[10:1], w_jimm[11], w_jimm[19:12], (w_c[15] ? 5'd0 : 5'd1), OPC_JAL};
                    5'b01_010: instr_o = {{7{w_c[12]}}, w_c[6:2], 5'd0, 3'b000, w_c[11:7], OPC_OP_IMM};
                    5'b01_011: begin
                        illegal_o = ({w_c[12], w_c[6:2]} == 6'h00);
                        if (w_c[11:7] == 5'd2) begin
                            instr_o = {{2{w_c[12]}}, w_c[12], w_c[4:3], w_c[5], w_c[2], w_c[6], 4'b0000,
                                       5'd2, 3'b000, 5'd2, OPC_OP_IMM};
                        end else begin
                            instr_o = {{15{w_c[12]}}, w_c[6:2], w_c[11:7], OPC_LUI};
                        end
                    end
                    5'b01_100: begin
                        case (w_c[11:10])
                            2'b00: begin
                                instr_o   = {7'b0000000, w_c[6:2], w_rdp, 3'b101, w_rdp, OPC_OP_IMM};
                                illegal_o = w_c[12];
                            end
                            2'b01: begin
                                instr_o   = {7'b0100000, w_c[6:2], w_rdp, 3'b101, w_rdp, OPC_OP_IMM};
                                illegal_o = w_c[12];
                            end
                            2'b10: instr_o = {{7{w_c[12]}}, w_c[6:2], w_rdp, 3'b111, w_rdp, OPC_OP_IMM};
                            default: begin
                                instr_o   = {((w_c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000), w_rs2p, w_rdp,
                                             w_alu_f3, w_rdp, OPC_OP};
                                illegal_o = w_c[12];
                            end
                        endcase
                    end
                    5'b01_110, 5'b01_111:
                        instr_o = {w_bimm[12], w_bimm[10:5], 5'd0, w_rdp, {2'b00, w_c[13]}, w_bimm[4:1], w_bimm[11], OPC_BRANCH};
                    5'b10_000: begin
                        instr_o   = {7'b0000000, w_c[6:2], w_c[11:7], 3'b001, w_c[11:7], OPC_OP_IMM};
                        illegal_o = w_c[12];
                    end
                    5'b10_010: begin
                        instr_o   = {4'b0, w_c[3:2], w_c[12], w_c[6:4], 2'b00, 5'd2, 3'b010, w_c[11:7], OPC_LOAD};
                        illegal_o = (w_c[11:7] == 5'd0);
                    end
                    5'b10_100: begin
                        if (!w_c[12]) begin
                            if (w_c[6:2] == 5'd0) begin
                                instr_o   = {12'h000, w_c[11:7], 3'b000, 5'd0, OPC_JALR};
                                illegal_o = (w_c[11:7] == 5'd0);
                            end else begin
                                instr_o = {7'b0000000, w_c[6:2], 5'd0, 3'b000, w_c[11:7], OPC_OP};
                            end
                        end else if (w_c[6:2] == 5'd0) begin
                            instr_o = (w_c[11:7] == 5'd0) ? INSTR_EBREAK
                                                          : {12'h000, w_c[11:7], 3'b000, 5'd1, OPC_JALR};
                        end else begin
                            instr_o = {7'b0000000, w_c[6:2], w_c[11:7], 3'b000, w_c[11:7], OPC_OP};
                        end
                    end
                    5'b10_110: instr_o = {4'b0, w_c[8:7], w_c[12], w_c[6:2], 5'd2, 3'b010, w_c[11:9], 2'b00, OPC_STORE};
                    default:   illegal_o = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_align_buffer.sv
// Halfword circular buffer between the fetch bus and decode: realigns
// compressed and 32-bit instructions that straddle fetch beats.
module fetch_align_buffer
    import ceres_param::*;
#(
    parameter int unsigned FETCH_W  = 32,
    parameter int unsigned DEPTH    = 8,
    parameter bit          C_EXT_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [FETCH_W-1:0] fetch_data_i,
    input  logic [31:0]        fetch_pc_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_o,
    output logic [31:0]        instr_raw_o,
    output logic [31:0]        instr_pc_o,
    output logic               is_compressed_o,
    output logic               illegal_instr_o
);

    localparam int unsigned HW    = FETCH_W / 16;
    localparam int unsigned OFF_W = $clog2(HW);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (!fab_params_ok(FETCH_W, DEPTH)) begin : g_param_check
        $error("fetch_align_buffer: illegal FETCH_W/DEPTH combination");
    end

    logic [15:0]      r_buf [DEPTH];
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_pc;
    logic             r_first;

    logic [15:0]      w_h0;
    logic [15:0]      w_h1;
    logic [31:0]      w_dec_instr;
    logic             w_dec_c;
    logic             w_dec_ill;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic [OFF_W-1:0] w_skip;
    logic [CNT_W-1:0] w_push_n;
    logic [CNT_W-1:0] w_pop_n;
    aligned_instr_t   w_out;

    assign w_h0 = r_buf[r_rptr];
    assign w_h1 = r_buf[r_rptr + PTR_W'(1)];

    compressed_decoder #(
        .C_EXT_EN (C_EXT_EN)
    ) u_cdec (
        .instr_i         ({w_h1, w_h0}),
        .instr_o         (w_dec_instr),
        .is_compressed_o (w_dec_c),
        .illegal_o       (w_dec_ill)
    );

    // Ready depends only on registered occupancy, never on the consumer.
    assign fetch_ready_o = (r_cnt <= CNT_W'(DEPTH - HW));
    assign w_valid       = ((r_cnt != '0) && w_dec_c) || (r_cnt >= CNT_W'(2));
    assign w_push        = fetch_valid_i && fetch_ready_o;
    assign w_pop         = w_valid && instr_ready_i;
    assign w_skip        = r_first ? fetch_pc_i[OFF_W:1] : '0;
    assign w_push_n      = w_push ? (CNT_W'(HW) - CNT_W'(w_skip)) : '0;
    assign w_pop_n       = w_pop ? (w_dec_c ? CNT_W'(1) : CNT_W'(2)) : '0;

    // The first beat after reset/flush drops halfwords ahead of the target PC.
    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i && !flush_i) begin
            for (int i = 0; i < int'(HW); i++) begin
                if (i >= int'(w_skip)) begin
                    r_buf[r_wptr + PTR_W'(i - int'(w_skip))] <= fetch_data_i[16*i +: 16];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_first <= 1'b1;
        end else if (flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_first <= 1'b1;
        end else begin
            r_rptr <= r_rptr + PTR_W'(w_pop_n);
            r_wptr <= r_wptr + PTR_W'(w_push_n);
            r_cnt  <= r_cnt + w_push_n - w_pop_n;
            if (w_push) begin
                r_first <= 1'b0;
            end
            if (w_push && r_first) begin
                r_pc <= fetch_pc_i;
            end else if (w_pop) begin
                r_pc <= r_pc + (w_dec_c ? 32'd2 : 32'd4);
            end
        end
    end

    assign w_out = '{
        instr:         w_dec_instr,
        raw:           w_dec_c ? {16'h0000, w_h0} : {w_h1, w_h0},
        pc:            r_pc,
        is_compressed: w_dec_c,
        illegal:       w_dec_ill
    };

    assign instr_valid_o   = w_valid;
    assign instr_o         = w_out.instr;
    assign instr_raw_o     = w_out.raw;
    assign instr_pc_o      = w_out.pc;
    assign is_compressed_o = w_out.is_compressed;
    assign illegal_instr_o = w_out.illegal;

endmodule

// File: doc/fetch_align_buffer.md
FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

Interface
REQ-001 SHALL have parameter FETCH_W, default 32, meaning fetch bus width in bits; legal values are 32, 64 and 128 (HW = FETCH_W/16 halfwords per fetch).
REQ-002 SHALL have parameter DEPTH, default 8, meaning buffer capacity in halfwords; it is a power of two and >= 2*HW.
REQ-003 SHALL have parameter C_EXT_EN, default 1, meaning the RVC extension is enabled.
REQ-004 SHALL have the following ports, clock and reset first (one clock; reset synchronous, active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard buffered contents (redirect)
- fetch_valid_i  in  1  fetch beat valid
- fetch_ready_o  out  1  buffer can accept one full beat
- fetch_data_i  in  FETCH_W  fetch beat, halfword 0 in bits [15:0]
- fetch_pc_i  in  32  byte address of the beat's target instruction, halfword aligned
- instr_valid_o  out  1  aligned instruction available
- instr_ready_i  in  1  consumer accepts the instruction
- instr_o  out  32  expanded 32-bit instruction
- instr_raw_o  out  32  raw bits; upper 16 bits are zero when compressed
- instr_pc_o  out  32  byte PC of instr_o
- is_compressed_o  out  1  source instruction was 16-bit
- illegal_instr_o  out  1  illegal/reserved compressed encoding

Function
REQ-005 SHALL store halfwords in a circular buffer of DEPTH entries, with read pointer, write pointer and occupancy counter cnt (0..DEPTH).
REQ-006 SHALL assert fetch_ready_o exactly when DEPTH - cnt >= HW, evaluated on the registered cnt with no combinational path from instr_ready_i.
- A beat transfers when fetch_valid_i && fetch_ready_o.
REQ-007 On the first beat after reset or flush, SHALL discard the halfwords below offset off = fetch_pc_i[log2(FETCH_W/8)-1:1] and write HW-off halfwords.
- SHALL load the PC register with fetch_pc_i.
- On all later beats, SHALL write all HW halfwords and ignore fetch_pc_i.
REQ-008 SHALL classify the head halfword h0 as compressed when h0[1:0] != 2'b11 and C_EXT_EN = 1.
REQ-009 SHALL drive instr_valid_o = (cnt >= 1 && compressed) || (cnt >= 2).
- A 32-bit instruction whose upper half has not yet arrived SHALL hold instr_valid_o low (boundary straddle).
REQ-010 On instr_valid_o && instr_ready_i, SHALL pop 1 halfword (compressed) or 2 halfwords (otherwise), and advance the PC register by 2 or 4.
REQ-011 SHALL allow push and pop in the same cycle; cnt_next = cnt + pushed - popped, and pointers wrap modulo DEPTH.
REQ-012 SHALL produce outputs combinationally from the buffer head; latency from an accepted beat to instr_valid_o is exactly 1 cycle.
REQ-013 SHALL produce instr_o through the compressed-expansion logic for compressed instructions and pass through h1:h0 otherwise.
REQ-014 SHALL drive illegal_instr_o = 1 when C_EXT_EN = 0 and h0[1:0] != 2'b11.
- In that case the instruction SHALL be treated as 32-bit (pop 2).
REQ-015 flush_i SHALL take priority over push and pop in the same cycle.
- Next cycle: cnt = 0, pointers = 0, instr_valid_o = 0, first-beat flag set.
- A beat presented in the flush cycle SHALL be dropped.
REQ-016 SHALL hold all outputs stable while instr_valid_o && !instr_ready_i.
REQ-017 SHALL make the outputs "don't care" except instr_valid_o when instr_valid_o = 0; the bench SHALL check them only while valid.

Reset
REQ-018 rst_i SHALL set cnt = 0, both pointers = 0, PC register = 0 and the first-beat flag = 1.
REQ-019 During and immediately after reset, SHALL drive instr_valid_o = 0 and fetch_ready_o = 1.
REQ-020 Reset asserted mid-operation SHALL discard any partially buffered straddling instruction.
REQ-021 Buffer data storage SHALL need no reset.

Structure
REQ-022 SHALL take opcode constants, FETCH_W/DEPTH legality limits and a typedef for the aligned-instruction bundle {instr, raw, pc, is_compressed, illegal} from ceres_param.
REQ-023 SHALL instantiate exactly one sub-module, compressed_decoder (32-bit in, 32-bit expanded out, is_compressed, illegal), on the head halfwords.
REQ-024 SHALL reject an illegal parameter combination with an elaboration-time assertion.

Verification
REQ-025 Reset, then beat 0x00000413_4501 (FETCH_W=32, data 0x04134501, pc 0x0) -> c.li x10,0 at pc 0x0 expands to 0x00000513; the next output is 0x0413 half pending (instr_valid_o = 0 until the next beat).
REQ-026 Straddle: beat0 = 0x00134501, beat1 = 0x00000000 -> cycle 1 outputs c.li at pc 0; then 32-bit 0x00000013 (nop) at pc 2, valid only after beat1 is accepted.
REQ-027 Misaligned start: flush, then beat 0x45014501 with fetch_pc_i = 0x102 -> exactly one c.li at pc 0x102; halfword 0 is discarded.
REQ-028 Full/backpressure: DEPTH=8, instr_ready_i = 0, 4 beats -> fetch_ready_o drops after beat 4 (cnt = 8); raising instr_ready_i re-asserts it once cnt <= 6.
REQ-029 Flush with a simultaneous beat and pop -> next cycle cnt = 0, instr_valid_o = 0, and the flushed beat never appears.
REQ-030 C_EXT_EN = 0 with halfword 0x0000 -> illegal_instr_o = 1, is_compressed_o = 0, and the PC advances by 4.
